// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, default oversampling and
// parity helpers used by both the receiver and the future parametrised TX.
package uart_pkg;

  localparam int   OVERSAMPLE_DEF = 16;
  localparam int   MAX_DATA_BITS  = 9;
  localparam logic PAR_EVEN       = 1'b0;
  localparam logic PAR_ODD        = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  // Zero-extended data leaves the XOR unchanged, so one width serves every frame size.
  function automatic logic parity_err(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     par_bit,
                                      input logic                     odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Reset-to-1 input synchroniser plus one extra flop for falling-edge detection;
// presetting to the idle level keeps reset release from looking like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_prev
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Next-state of the shift chain and the edge-detect flop.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_prev = prev_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling on oversample ticks, optional
// parity, 1 or 2 stop bits, with held parity/framing error flags per frame.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_reset_n,
  input  logic                 i_tick,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_Done,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1'b1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1'b1);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic rx_s;
  logic rx_prev;

  rx_state_e               state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic                    perr_pend_q, perr_pend_d;
  logic                    ferr_pend_q, ferr_pend_d;
  logic                    done_q, done_d;
  logic [DATA_BITS-1:0]    byte_q, byte_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    busy_q, busy_d;

  logic [TW-1:0] tick_inc_s;
  logic          tick_mid_s;
  logic          tick_full_s;
  logic          ferr_now_s;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_Clock),
    .i_rst_n (i_reset_n),
    .i_async (i_Rx_Serial),
    .o_sync  (rx_s),
    .o_prev  (rx_prev)
  );

  // OVERSAMPLE need not be a power of two, so the counter wraps explicitly.
  assign tick_inc_s  = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_ONE;
  assign tick_mid_s  = i_tick & (tick_q == TICK_MID);
  assign tick_full_s = i_tick & (tick_q == TICK_LAST);
  assign ferr_now_s  = ferr_pend_q | ~rx_s;

  // Frame sequencing, bit capture and output commit.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    data_d      = data_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    done_d      = 1'b0;
    byte_d      = byte_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (rx_prev && !rx_s) begin
          state_d     = ST_START;
          bit_d       = '0;
          stop_d      = 1'b0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_mid_s) begin
          tick_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else if (i_tick) begin
          tick_d = tick_inc_s;
        end else begin
          tick_d = tick_q;
        end
      end
      ST_DATA: begin
        tick_d = i_tick ? tick_inc_s : tick_q;
        if (tick_full_s) begin
          data_d = {rx_s, data_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          bit_d = bit_q;
        end
      end
      ST_PARITY: begin
        tick_d = i_tick ? tick_inc_s : tick_q;
        if (tick_full_s) begin
          perr_pend_d = parity_err(MAX_DATA_BITS'(data_q), rx_s, PAR_MODE);
          state_d     = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        tick_d = i_tick ? tick_inc_s : tick_q;
        if (tick_full_s && (stop_q == STOP_LAST)) begin
          state_d = ST_DONE;
          stop_d  = 1'b0;
          done_d  = 1'b1;
          byte_d  = data_q;
          perr_d  = perr_pend_q;
          ferr_d  = ferr_now_s;
        end else if (tick_full_s) begin
          stop_d      = 1'b1;
          ferr_pend_d = ferr_now_s;
        end else begin
          stop_d = stop_q;
        end
      end
      ST_DONE: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_Clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      data_q      <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      done_q      <= 1'b0;
      byte_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      data_q      <= data_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      done_q      <= done_d;
      byte_q      <= byte_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign o_Rx_Done    = done_q;
  assign o_Rx_Byte    = byte_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) driven from a
// shared tick, checked with a vector table, corner sequences and random frames.
module tb_uart_rx_param;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic rx_a, rx_p, rx_c;
  logic done_a, done_p, done_c;
  logic [7:0] byte_a, byte_p;
  logic [6:0] byte_c;
  logic perr_a, perr_p, perr_c;
  logic ferr_a, ferr_p, ferr_c;
  logic busy_a, busy_p, busy_c;

  always #5 clk = ~clk;

  uart_rx_param dut_a (
    .i_Clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_Rx_Serial(rx_a),
    .o_Rx_Done(done_a), .o_Rx_Byte(byte_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_busy(busy_a)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_Clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_Rx_Serial(rx_p),
    .o_Rx_Done(done_p), .o_Rx_Byte(byte_p), .o_parity_err(perr_p),
    .o_frame_err(ferr_p), .o_busy(busy_p)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_Rx_Serial(rx_c),
    .o_Rx_Done(done_c), .o_Rx_Byte(byte_c), .o_parity_err(perr_c),
    .o_frame_err(ferr_c), .o_busy(busy_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tick_div = 1;
  int n_done [3] = '{0, 0, 0};
  int done_cyc [3] = '{0, 0, 0};
  logic [8:0] cap_byte [3];
  logic cap_perr [3];
  logic cap_ferr [3];

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    logic [8:0] exp_byte;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [8];

  // Tick source: a pulse every tick_div cycles (tick_div = 1 holds it high).
  initial begin
    int tc;
    tc = 0;
    tick = 1'b1;
    forever begin
      @(negedge clk);
      tc++;
      if (tc >= tick_div) begin
        tc = 0;
        tick = 1'b1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Done monitor: counts pulses and captures outputs per instance.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done_a) begin
        n_done[0]++; done_cyc[0] = cyc;
        cap_byte[0] = {1'b0, byte_a}; cap_perr[0] = perr_a; cap_ferr[0] = ferr_a;
      end
      if (done_p) begin
        n_done[1]++; done_cyc[1] = cyc;
        cap_byte[1] = {1'b0, byte_p}; cap_perr[1] = perr_p; cap_ferr[1] = ferr_p;
      end
      if (done_c) begin
        n_done[2]++; done_cyc[2] = cyc;
        cap_byte[2] = {2'b00, byte_c}; cap_perr[2] = perr_c; cap_ferr[2] = ferr_c;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_p = v;
      2: rx_c = v;
      default: rx_a = v;
    endcase
  endtask

  task automatic drive_bit(input int sel, input logic v, input int n);
    set_line(sel, v);
    wait_ticks(n);
  endtask

  function automatic int nbits_of(input int sel);
    return (sel == 2) ? 7 : 8;
  endfunction

  // Reference model: frame rules expressed directly on the transmitted values.
  function automatic logic [8:0] model_byte(input int sel, input logic [8:0] d);
    logic [8:0] mask;
    mask = 9'((1 << nbits_of(sel)) - 1);
    return d & mask;
  endfunction

  function automatic logic model_perr(input int sel, input logic [8:0] d, input logic p);
    int ones;
    if (sel != 1) return 1'b0;
    ones = $countones(model_byte(sel, d)) + int'(p);
    return (ones % 2) != 0;
  endfunction

  function automatic logic model_ferr(input int sel, input logic [1:0] stops);
    if (sel == 2) return stops != 2'b11;
    return !stops[0];
  endfunction

  task automatic send_frame(input int sel, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    drive_bit(sel, 1'b0, OS);
    for (int i = 0; i < nbits_of(sel); i++) drive_bit(sel, data[i], OS);
    if (sel == 1) drive_bit(sel, pbit, OS);
    drive_bit(sel, stops[0], OS);
    if (sel == 2) drive_bit(sel, stops[1], OS);
    set_line(sel, 1'b1);
  endtask

  task automatic run_frame(input string tag, input int sel, input logic [8:0] data,
                           input logic pbit, input logic [1:0] stops,
                           input logic [8:0] eb, input logic ep, input logic ef);
    int base;
    base = n_done[sel];
    send_frame(sel, data, pbit, stops);
    wait_ticks(2 * OS);
    check({tag, "_done_cnt"}, 32'(n_done[sel] - base), 32'd1);
    check({tag, "_byte"}, 32'(cap_byte[sel]), 32'(eb));
    check({tag, "_perr"}, 32'(cap_perr[sel]), 32'(ep));
    check({tag, "_ferr"}, 32'(cap_ferr[sel]), 32'(ef));
  endtask

  initial begin
    int base;
    int t0;
    int lat;
    int sel;
    logic [8:0] d;
    logic pb;
    logic [1:0] st;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h037, 1'b0, 2'b11, 9'h037, 1'b1, 1'b0};
    vecs[2] = '{1, 9'h037, 1'b1, 2'b11, 9'h037, 1'b0, 1'b0};
    vecs[3] = '{2, 9'h055, 1'b0, 2'b01, 9'h055, 1'b0, 1'b1};
    vecs[4] = '{2, 9'h02A, 1'b0, 2'b11, 9'h02A, 1'b0, 1'b0};
    vecs[5] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    vecs[6] = '{1, 9'h080, 1'b0, 2'b11, 9'h080, 1'b1, 1'b0};
    vecs[7] = '{1, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};

    rst_n = 1'b0;
    rx_a = 1'b1; rx_p = 1'b1; rx_c = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_byte", 32'(byte_a), 32'd0);
    check("rst_perr", 32'(perr_a), 32'd0);
    check("rst_ferr", 32'(ferr_a), 32'd0);
    check("rst_busy", 32'(busy_a | busy_p | busy_c), 32'd0);
    rst_n = 1'b1;
    wait_ticks(OS);
    check("idle_busy", 32'(busy_a | busy_p | busy_c), 32'd0);

    for (int i = 0; i < 8; i++) begin
      t0 = cyc;
      run_frame($sformatf("v%0d", i), vecs[i].sel, vecs[i].data, vecs[i].pbit,
                vecs[i].stops, vecs[i].exp_byte, vecs[i].exp_perr, vecs[i].exp_ferr);
      if (i == 0) begin
        lat = done_cyc[0] - t0;
        check("latency_window", 32'((lat >= OS * 9 + OS / 2) && (lat <= OS * 10 + 4)), 32'd1);
      end
    end

    // Stop bit low then line held low: one Done with frame error, no re-trigger.
    base = n_done[0];
    drive_bit(0, 1'b0, OS * 13);
    check("brk_done_cnt", 32'(n_done[0] - base), 32'd1);
    check("brk_byte", 32'(cap_byte[0]), 32'd0);
    check("brk_ferr", 32'(cap_ferr[0]), 32'd1);
    check("brk_busy_low", 32'(busy_a), 32'd0);
    drive_bit(0, 1'b1, OS * 2);
    check("brk_no_retrig", 32'(n_done[0] - base), 32'd1);
    run_frame("after_brk", 0, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0);

    // Four-tick glitch: false start rejected, outputs left alone.
    base = n_done[0];
    drive_bit(0, 1'b0, 4);
    check("glitch_busy_hi", 32'(busy_a), 32'd1);
    drive_bit(0, 1'b1, OS / 2);
    check("glitch_busy_lo", 32'(busy_a), 32'd0);
    wait_ticks(OS * 2);
    check("glitch_no_done", 32'(n_done[0] - base), 32'd0);
    check("glitch_byte", 32'(byte_a), 32'h5A);
    check("glitch_ferr", 32'(ferr_a), 32'd0);

    for (int r = 0; r < 30; r++) begin
      tick_div = int'($urandom_range(1, 3));
      wait_ticks(2);
      sel = int'($urandom_range(0, 2));
      d = 9'($urandom);
      pb = 1'($urandom);
      st[0] = ($urandom_range(0, 4) != 0);
      st[1] = ($urandom_range(0, 4) != 0);
      run_frame($sformatf("rnd%0d", r), sel, d, pb, st,
                model_byte(sel, d), model_perr(sel, d, pb), model_ferr(sel, st));
    end

    // Reset in the middle of the data bits of 0xFF.
    tick_div = 1;
    wait_ticks(2);
    base = n_done[0];
    drive_bit(0, 1'b0, OS);
    drive_bit(0, 1'b1, OS * 3 + OS / 2);
    check("mid_busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_byte", 32'(byte_a), 32'd0);
    check("mid_rst_errs", 32'({perr_a, ferr_a}), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(OS * 8);
    check("mid_no_done", 32'(n_done[0] - base), 32'd0);
    run_frame("post_rst", 0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, optional even/odd parity, 1 or 2 stop bits, and mid-bit sampling driven by an oversampling tick. It reports parity and framing errors, and rejects false starts. It sits between the pad input and the RX-side consumer (FIFO/interface block), and is clocked by the system clock with ticks from the shared baud generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
OVERSAMPLE, 16, i_tick pulses per bit period; even, >= 4.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
SYNC_STAGES, 2, flops in the input synchroniser; >= 2.

Ports:
i_Clock  in  1  system clock; all logic on its rising edge.
i_reset_n  in  1  asynchronous, active-low reset.
i_tick  in  1  oversample tick; single-cycle pulse, OVERSAMPLE per bit period.
i_Rx_Serial  in  1  asynchronous serial line; idles high.
o_Rx_Done  out  1  single-cycle pulse; frame complete and outputs valid.
o_Rx_Byte  out  DATA_BITS  last received data word; held until the next o_Rx_Done.
o_parity_err  out  1  parity mismatch on the last frame; held; 0 when PARITY_EN = 0.
o_frame_err  out  1  a stop bit sampled low on the last frame; held.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs 0; synchroniser flops preset to 1 so release cannot fake a start bit; tick counter and bit counter 0.
- Input path: i_Rx_Serial passes SYNC_STAGES flops to give rx_s. One more flop gives rx_prev. All decisions use rx_s.
- Tick counter width is clog2(OVERSAMPLE). It advances only on cycles where i_tick = 1.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: a falling edge (rx_prev = 1, rx_s = 0) moves to START and clears the tick counter. A line held low (break, or low after a frame error) never re-triggers until it has gone high.
- START: on the tick where the count reaches OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s = 1: false start; return to IDLE with no output change.
  - rx_s = 0: clear the counter and go to DATA.
- DATA: on every OVERSAMPLE-th tick, sample rx_s into bit[bit_idx], LSB first, then increment bit_idx. Sampling falls at mid-bit.
  - After sample DATA_BITS-1: go to PARITY if PARITY_EN, else STOP. bit_idx resets to 0.
- PARITY: on the OVERSAMPLE-th tick, sample p. Error = (XOR of data bits) ^ p ^ PARITY_ODD.
- STOP: sample every OVERSAMPLE ticks, STOP_BITS times. Any low sample sets the pending frame error. After the last stop sample, go to DONE.
- DONE: lasts exactly one cycle.
  - o_Rx_Done = 1.
  - o_Rx_Byte, o_parity_err and o_frame_err update in the same cycle.
  - Next state is IDLE.
- Latency: o_Rx_Done asserts on the cycle after the clock edge that samples the last stop bit. Line-to-sample delay is SYNC_STAGES cycles.
- Data and errors are committed even on error; the consumer decides whether to drop the frame. Erroneous frames are never silently discarded.
- i_tick may be held at 1, meaning oversample = clock. i_tick pulses in DONE/IDLE are ignored.
- Reset asserted mid-frame: the frame is aborted immediately and no o_Rx_Done follows. After release, reception resumes from IDLE.
- Illegal state encoding: recover to IDLE on the next clock.

Decomposition:
- Package uart_pkg: state enumeration localparams, default OVERSAMPLE, and parity mode constants (PAR_EVEN = 0, PAR_ODD = 1). The future parametrised TX shares this package.
- Sub-module uart_rx_sync (SYNC_STAGES-deep, reset-to-1 synchroniser plus edge-detect flop). It is reused by the TX CTS input.

Test Plan:
Default 8N1, i_tick = 1, send 0xA5 -> exactly one o_Rx_Done pulse; o_Rx_Byte = 0xA5; o_parity_err = 0; o_frame_err = 0.
Line low for 4 ticks, then high (glitch) -> no o_Rx_Done; o_busy returns to 0 within OVERSAMPLE/2 ticks; outputs unchanged.
PARITY_EN = 1 (even), send 0x37 with parity bit 0 instead of 1 -> o_Rx_Byte = 0x37, o_parity_err = 1. Then send 0x37 with parity 1 -> o_parity_err = 0.
Send 0x00 with stop bit 0 and hold line low 3 bit times -> one o_Rx_Done, o_frame_err = 1, no further Done while low. After the line goes high, 0x5A is received with o_frame_err = 0.
DATA_BITS = 7, STOP_BITS = 2, send 0x55 with the second stop bit 0 -> o_Rx_Byte = 7'h55, o_frame_err = 1.
Assert i_reset_n low mid-DATA of byte 0xFF -> outputs 0 and no Done. After release, 0x3C is received correctly with Done once.
